exe_mem_skid_reg: RTL and testbench
===================================

// Module: exe_mem_skid_reg
// PURPOSE
//  EXE->MEM pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Lets the MEM stage stall (e.g. slow data memory) without a combinational ready
//  path back into EXE; flush kills in-flight entries on branch taken.
//  Sits between the EXE stage and the MEM stage.
// PARAMETERS
//  BIT_NUMBER  32  width of alu_result / val_rm
//  DEST_W      4   width of destination register index
//  CNT_W       16  width of stall counter (EXE_REG_STATS_EN only)
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           async reset, active-high
//  flush          in   1           sync: discard all held and incoming entries
//  in_valid       in   1           EXE presents an entry
//  in_ready       out  1           registered; entry accepted when in_valid&in_ready
//  wb_en_in       in   1           write-back enable
//  mem_r_en_in    in   1           memory read enable
//  mem_w_en_in    in   1           memory write enable
//  alu_result_in  in   BIT_NUMBER  ALU result / address
//  val_rm_in      in   BIT_NUMBER  store data
//  dest_in        in   DEST_W      destination register
//  out_valid      out  1           MEM-side entry valid
//  out_ready      in   1           MEM consumes entry when out_valid&out_ready
//  wb_en, mem_r_en, mem_w_en  out  1 each  control of head entry, forced 0 when out_valid=0
//  alu_result, val_rm  out  BIT_NUMBER  data of head entry
//  dest           out  DEST_W      destination of head entry
//  stall_cnt      out  CNT_W       only with EXE_REG_STATS_EN
// BEHAVIOUR
//  Storage: head register (drives outputs) + skid register. State = occupancy:
//   EMPTY (0), ONE (head only), FULL (head+skid). in_ready = (state != FULL), registered.
//  Per rising edge, acc = in_valid&in_ready, pop = out_valid&out_ready:
//   EMPTY: acc -> head<=in, ONE.                        No acc -> stay.
//   ONE:   acc&pop -> head<=in, ONE. acc&!pop -> skid<=in, FULL.
//          !acc&pop -> EMPTY.        neither -> hold.
//   FULL:  pop -> head<=skid, ONE (in_ready=0 so no acc). !pop -> hold.
//  Zero-bubble: back-to-back accept and pop sustains 1 entry/cycle, latency 1 cycle
//   (in at edge N visible on outputs after edge N).
//  Order preserved: skid entry always follows head entry.
//  flush has priority over all: next state EMPTY, in_ready=1; an entry presented
//   in the flush cycle is dropped; out_valid=0 next cycle. Data regs may keep stale
//   values; control outputs read 0 because out_valid=0.
//  Data registers load only on acc/shift (no toggling while stalled).
//  Reset (async, any time incl. mid-stall): state EMPTY, out_valid=0, in_ready=1,
//   all control/data outputs 0, skid cleared; first accept possible on first edge
//   after rst deasserts.
//  out_valid, out_ready relation: MEM may hold out_ready=0 indefinitely; outputs stable.
// CONFIGURATION
//  EXE_REG_STATS_EN defined: stall_cnt increments each cycle out_valid&!out_ready,
//   saturates at 2^CNT_W-1 (no wrap), cleared only by rst (not by flush).
//  Not defined: stall_cnt port absent, no counter logic.
// TESTING
//  T1 reset: rst=1 mid-traffic -> out_valid=0, in_ready=1, wb_en=0, alu_result=0.
//  T2 stream: out_ready=1, push alu 0x10,0x20,0x30 on 3 edges -> appear in order
//   one edge later each, in_ready stays 1, no bubbles.
//  T3 skid: out_ready=0, push 0xA then 0xB -> state FULL, in_ready=0, head=0xA;
//   raise out_ready -> 0xA then 0xB popped in order, in_ready=1 after first pop.
//  T4 flush: FULL with 0xA/0xB, flush=1 with in_valid=1 (0xC) -> next cycle
//   out_valid=0, mem_w_en=0, in_ready=1; 0xC never appears.
//  T5 ctrl gating: push mem_w_en_in=1 then drain -> mem_w_en=1 only while out_valid=1.
//  T6 stats (EXE_REG_STATS_EN, CNT_W=4): hold out_ready=0 for 20 cycles with valid
//   head -> stall_cnt=15 (saturated); flush -> still 15; rst -> 0.

Source files
------------

// File: rtl/exe_mem_skid_reg.sv
// exe_mem_skid_reg: EXE->MEM pipeline register with a 2-entry skid buffer and flush; optional stall counter under EXE_REG_STATS_EN
module exe_mem_skid_reg #(
  parameter int BIT_NUMBER = 32,
  parameter int DEST_W     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [BIT_NUMBER-1:0] alu_result_in,
  input  logic [BIT_NUMBER-1:0] val_rm_in,
  input  logic [DEST_W-1:0]     dest_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  wb_en,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic [BIT_NUMBER-1:0] alu_result,
  output logic [BIT_NUMBER-1:0] val_rm,
  output logic [DEST_W-1:0]     dest
`ifdef EXE_REG_STATS_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt
`endif
);
  localparam int EW = 3 + 2 * BIT_NUMBER + DEST_W;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic [EW-1:0] head_q, head_d, skid_q, skid_d, in_e;
  logic          acc, pop;
  assign in_e      = {wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, val_rm_in, dest_in};
  assign in_ready  = in_ready_q;
  assign out_valid = state_q != EMPTY;
  assign acc       = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  assign wb_en     = out_valid & head_q[EW-1];
  assign mem_r_en  = out_valid & head_q[EW-2];
  assign mem_w_en  = out_valid & head_q[EW-3];
  assign alu_result = head_q[DEST_W+BIT_NUMBER +: BIT_NUMBER];
  assign val_rm    = head_q[DEST_W +: BIT_NUMBER];
  assign dest      = head_q[DEST_W-1:0];
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) state_d = EMPTY;
    else if (state_q == EMPTY) begin
      if (acc) begin
        head_d  = in_e;
        state_d = ONE;
      end
    end else if (state_q == ONE) begin
      if (acc && pop) head_d = in_e;
      else if (acc) begin
        skid_d  = in_e;
        state_d = FULL;
      end else if (pop) state_d = EMPTY;
    end else if (pop) begin
      head_d  = skid_q;
      state_d = ONE;
    end
    in_ready_d = state_d != FULL;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end
`ifdef EXE_REG_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  assign stall_cnt = stall_cnt_q;
  always_comb stall_cnt_d = (out_valid && !out_ready && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
`endif
endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// tb_exe_mem_skid_reg: directed self-checking bench for exe_mem_skid_reg
module tb_exe_mem_skid_reg;
  logic        clk = 0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, wb_en, mem_r_en, mem_w_en;
  logic [31:0] alu_result_in, val_rm_in, alu_result, val_rm;
  logic [3:0]  dest_in, dest;
`ifdef EXE_REG_STATS_EN
  logic [3:0]  stall_cnt;
`endif
  int pass_cnt = 0, fail_cnt = 0, total = 0;
  always #5 clk = ~clk;
  exe_mem_skid_reg #(.BIT_NUMBER(32), .DEST_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_result_in(alu_result_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .alu_result(alu_result), .val_rm(val_rm), .dest(dest)
`ifdef EXE_REG_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] a);
    in_valid = 1;
    alu_result_in = a;
    tick();
  endtask
  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 1;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    alu_result_in = 0; val_rm_in = 0; dest_in = 0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu", alu_result, 0);
    #9 rst = 0;
    // T2 streaming
    wb_en_in = 1; mem_r_en_in = 1; val_rm_in = 32'h1234; dest_in = 4'd3;
    push(32'h10);
    chk("s1_valid", out_valid, 1);
    chk("s1_alu", alu_result, 32'h10);
    chk("s1_wb", wb_en, 1);
    chk("s1_rd", mem_r_en, 1);
    chk("s1_rm", val_rm, 32'h1234);
    chk("s1_dest", dest, 3);
    chk("s1_ready", in_ready, 1);
    wb_en_in = 0; mem_r_en_in = 0;
    push(32'h20);
    chk("s2_alu", alu_result, 32'h20);
    chk("s2_ready", in_ready, 1);
    chk("s2_wb", wb_en, 0);
    push(32'h30);
    chk("s3_alu", alu_result, 32'h30);
    chk("s3_valid", out_valid, 1);
    in_valid = 0;
    tick();
    chk("s_drain", out_valid, 0);
    // T3 skid
    out_ready = 0;
    push(32'hA);
    chk("k1_ready", in_ready, 1);
    push(32'hB);
    chk("k2_ready", in_ready, 0);
    chk("k2_alu", alu_result, 32'hA);
    push(32'hD);
    tick();
    chk("k_hold_alu", alu_result, 32'hA);
    chk("k_hold_ready", in_ready, 0);
    in_valid = 0; out_ready = 1;
    tick();
    chk("k3_alu", alu_result, 32'hB);
    chk("k3_ready", in_ready, 1);
    chk("k3_valid", out_valid, 1);
    tick();
    chk("k4_valid", out_valid, 0);
    // T4 flush
    out_ready = 0;
    push(32'hA);
    push(32'hB);
    flush = 1; mem_w_en_in = 1;
    push(32'hC);
    chk("f_valid", out_valid, 0);
    chk("f_wen", mem_w_en, 0);
    chk("f_ready", in_ready, 1);
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    chk("f_dropped", out_valid, 0);
    // T5 control gating
    out_ready = 0;
    push(32'h55);
    chk("g_wen_on", mem_w_en, 1);
    in_valid = 0; mem_w_en_in = 0; out_ready = 1;
    tick();
    chk("g_valid_off", out_valid, 0);
    chk("g_wen_off", mem_w_en, 0);
    // T1 async reset mid-stall
    out_ready = 0; wb_en_in = 1;
    push(32'h66);
    push(32'h67);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ready", in_ready, 1);
    chk("ar_wb", wb_en, 0);
    chk("ar_alu", alu_result, 0);
    #1 rst = 0;
    push(32'h77);
    chk("ar_first_alu", alu_result, 32'h77);
    chk("ar_first_wb", wb_en, 1);
    push(32'h78);
    in_valid = 0; out_ready = 1;
    tick();
    chk("ar_skid_alu", alu_result, 32'h78);
    tick();
`ifdef EXE_REG_STATS_EN
    // T6 stall counter saturation
    rst = 1; #1 rst = 0;
    chk("c_rst", stall_cnt, 0);
    out_ready = 0;
    push(32'h1);
    in_valid = 0;
    repeat (20) tick();
    chk("c_sat", stall_cnt, 15);
    flush = 1;
    tick();
    flush = 0;
    chk("c_flush", stall_cnt, 15);
    rst = 1; #1;
    chk("c_clear", stall_cnt, 0);
    rst = 0;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
